gif_frame_reader: RTL and testbench

Read-side sequencer for the dual-port GIF frame memory. Walks the frame address space, drives `address`/`rd` toward the memory (which registers its 24-bit `{RGB0,RGB1}` word on the falling clock edge), and streams each returned word as a top/bottom pixel pair over a valid/ready interface to the LED panel driver. It carries per-pixel line and frame markers, absorbs the memory's read latency under backpressure, and supports single-shot or looping frame playback.

---
 rtl/gif_frame_reader.sv | 155 +++++++++++++++
 tb/tb_gif_frame_reader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gif_frame_reader.sv
// Read-side sequencer for the dual-port GIF frame memory: issues frame reads, absorbs the
// one-cycle memory latency in a 2-entry FIFO and streams top/bottom pixel pairs with markers.
module gif_frame_reader #(
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = 12,
    parameter int COLS   = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           loop_en,
    output logic [ADDR_W-1:0]              mem_address,
    output logic                           mem_rd,
    input  logic [23:0]                    mem_rdata,
    output logic [11:0]                    pix_top,
    output logic [11:0]                    pix_bot,
    output logic                           pix_valid,
    input  logic                           pix_ready,
    output logic                           pix_sol,
    output logic                           pix_eol,
    output logic                           pix_eof,
    output logic [ADDR_W-$clog2(COLS)-1:0] pix_row,
    output logic                           busy,
    output logic                           frame_done
);

    localparam int                COL_W = $clog2(COLS);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_idx;
    logic [23:0]       r_fifo [2];
    logic              r_wr_sel;
    logic              r_rd_sel;
    logic [1:0]        r_occ;

    logic              w_push;
    logic              w_pop;
    logic [2:0]        w_level;
    logic              w_room;
    logic              w_frame_end;
    logic              w_issue;
    logic              w_restart;
    logic              w_done;
    logic              w_last_issue;
    logic [ADDR_W-1:0] w_issue_addr;
    logic [23:0]       w_head;

    // A read strobed on the previous edge was registered by the memory on the falling edge
    // and is captured now, so the strobe register doubles as the in-flight flag.
    assign w_push       = mem_rd;
    assign w_pop        = pix_valid & pix_ready;
    assign w_level      = 3'(r_occ) + 3'(w_push) - 3'(w_pop);
    assign w_room       = (w_level < 3'd2);
    assign w_frame_end  = (r_occ == 2'd0) && !w_push && (r_idx == '0);
    assign w_issue_addr = w_restart ? '0 : r_ptr;
    assign w_last_issue = w_issue && (w_issue_addr == LAST);

    // NOTE: state and data registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_RUN;
            S_DRAIN: if (w_frame_end) w_next_state = loop_en ? S_RUN : S_IDLE;
            default: w_next_state = r_state;
        endcase
        if (w_last_issue) w_next_state = S_DRAIN;
    end

    always_comb begin
        w_issue   = 1'b0;
        w_restart = 1'b0;
        w_done    = 1'b0;
        busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                w_issue   = start;
                w_restart = start;
            end
            S_RUN: w_issue = w_room;
            S_DRAIN: begin
                if (w_frame_end) begin
                    w_done    = 1'b1;
                    w_issue   = loop_en;
                    w_restart = loop_en;
                end
            end
            default: w_issue = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            mem_address <= '0;
            mem_rd      <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            mem_rd     <= w_issue;
            frame_done <= w_done;
            if (w_issue) begin
                mem_address <= w_issue_addr;
                r_ptr       <= w_issue_addr + 1'b1;
            end
        end
    end

    // NOTE: the two FIFO words are reset too; they are tiny and it keeps the head at zero
    // after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_wr_sel  <= 1'b0;
            r_rd_sel  <= 1'b0;
            r_occ     <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_sel] <= mem_rdata;
                r_wr_sel         <= ~r_wr_sel;
            end
            if (w_pop) r_rd_sel <= ~r_rd_sel;
            r_occ <= r_occ + 2'(w_push) - 2'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_idx <= '0;
        else if (w_restart) r_idx <= '0;
        else if (w_pop)     r_idx <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
    end

    // Head outputs and markers read as zero whenever the queue is empty.
    assign w_head    = r_fifo[r_rd_sel];
    assign pix_valid = (r_occ != 2'd0);
    assign pix_top   = pix_valid ? w_head[23:12] : '0;
    assign pix_bot   = pix_valid ? w_head[11:0]  : '0;
    assign pix_sol   = pix_valid && (r_idx[COL_W-1:0] == '0);
    assign pix_eol   = pix_valid && (r_idx[COL_W-1:0] == '1);
    assign pix_eof   = pix_valid && (r_idx == LAST);
    assign pix_row   = pix_valid ? r_idx[ADDR_W-1:COL_W] : '0;

endmodule

// File: tb/tb_gif_frame_reader.sv
// Bench for gif_frame_reader: falling-edge frame memory model, count-based queue model
// checked every cycle, and directed scenarios with literal expectations.
module tb_gif_frame_reader;

    localparam int DEPTH  = 2048;
    localparam int ADDR_W = 12;
    localparam int COLS   = 64;
    localparam int ROW_W  = ADDR_W - $clog2(COLS);

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              loop_en;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_rd;
    logic [23:0]       mem_rdata;
    logic [11:0]       pix_top;
    logic [11:0]       pix_bot;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_sol;
    logic              pix_eol;
    logic              pix_eof;
    logic [ROW_W-1:0]  pix_row;
    logic              busy;
    logic              frame_done;

    int n_checks = 0;
    int n_errors = 0;

    gif_frame_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .COLS(COLS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .loop_en(loop_en),
        .mem_address(mem_address), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .pix_top(pix_top), .pix_bot(pix_bot), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sol(pix_sol), .pix_eol(pix_eol), .pix_eof(pix_eof), .pix_row(pix_row),
        .busy(busy), .frame_done(frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [11:0] pat_top(input int i);
        return 12'(i);
    endfunction

    function automatic logic [11:0] pat_bot(input int i);
        return 12'(i * 5) ^ 12'hFFF;
    endfunction

    logic [23:0] mem [DEPTH];
    initial mem_rdata = '0;
    always @(negedge clk) if (mem_rd) mem_rdata <= mem[mem_address[10:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is a count of words issued, returned and accepted.
    bit s_rst, s_start, s_loop, s_ready, s_dut_pop;
    bit m_active, m_pend, m_rd, m_done, m_pop, m_issue;
    int m_iss, m_ret, m_acc, m_addr;
    int cyc, pop_total, first_pop, last_pop, done_total;

    initial begin : compare
        m_active = 0; m_pend = 0; m_rd = 0; m_done = 0;
        m_iss = 0; m_ret = 0; m_acc = 0; m_addr = 0;
        cyc = 0; pop_total = 0; first_pop = 0; last_pop = 0; done_total = 0;
        forever begin
            @(negedge clk);
            #4;
            s_rst     = rst_n;
            s_start   = start;
            s_loop    = loop_en;
            s_ready   = pix_ready;
            s_dut_pop = pix_valid && pix_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (s_rst && s_dut_pop) begin
                if (pop_total == 0) first_pop = cyc;
                last_pop = cyc;
                pop_total++;
            end
            if (frame_done) done_total++;

            if (!s_rst) begin
                m_active = 0; m_pend = 0; m_rd = 0; m_done = 0;
                m_iss = 0; m_ret = 0; m_acc = 0; m_addr = 0;
            end else begin
                m_pop   = (m_ret > m_acc) && s_ready;
                m_issue = 0;
                m_done  = 0;
                if (!m_active) begin
                    if (s_start) begin
                        m_active = 1; m_iss = 0; m_ret = 0; m_acc = 0; m_issue = 1;
                    end
                end else if (m_acc == DEPTH) begin
                    m_done = 1; m_iss = 0; m_ret = 0; m_acc = 0;
                    if (s_loop) m_issue = 1;
                    else        m_active = 0;
                end else begin
                    m_issue = (m_iss < DEPTH) && (m_iss - m_acc - int'(m_pop) < 2);
                    m_acc   = m_acc + int'(m_pop);
                    m_ret   = m_ret + int'(m_pend);
                end
                if (m_issue) begin
                    m_addr = m_iss;
                    m_iss++;
                end
                m_pend = m_issue;
                m_rd   = m_issue;
            end

            check("mem_rd", mem_rd, m_rd);
            check("mem_address", mem_address, m_addr);
            check("pix_valid", pix_valid, m_ret > m_acc);
            check("frame_done", frame_done, m_done);
            check("busy", busy, m_active);
            if (m_ret > m_acc) begin
                check("pix_top", pix_top, pat_top(m_acc));
                check("pix_bot", pix_bot, pat_bot(m_acc));
                check("pix_sol", pix_sol, (m_acc % COLS) == 0);
                check("pix_eol", pix_eol, (m_acc % COLS) == COLS - 1);
                check("pix_eof", pix_eof, m_acc == DEPTH - 1);
                check("pix_row", pix_row, m_acc / COLS);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_rd"}, mem_rd, 0);
        check({tag, "_addr"}, mem_address, 0);
        check({tag, "_valid"}, pix_valid, 0);
        check({tag, "_top"}, pix_top, 0);
        check({tag, "_bot"}, pix_bot, 0);
        check({tag, "_sol"}, pix_sol, 0);
        check({tag, "_eol"}, pix_eol, 0);
        check({tag, "_eof"}, pix_eof, 0);
        check({tag, "_row"}, pix_row, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, frame_done, 0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic idle_cycles(input string tag);
        int n = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (mem_rd) n++;
        end
        check({tag, "_rd_count"}, n, 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int  n;
        int  loops;
        bit  found;
        bit  dropped;
        rst_n = 1'b1; start = 1'b0; loop_en = 1'b0; pix_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = {pat_top(i), pat_bot(i)};

        // Reset asserted mid-cycle, then idle.
        #2 rst_n = 1'b0;
        #1 check_reset_values("por");
        @(negedge clk) rst_n = 1'b1;
        idle_cycles("idle0");

        // Short partial frame, then mid-cycle reset.
        @(negedge clk); pix_ready = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("rst_a");
        @(negedge clk) rst_n = 1'b1;
        idle_cycles("idle1");

        // Full frame at full rate.
        @(negedge clk);
        pop_total = 0; done_total = 0; loop_en = 1'b0; pix_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        check("lat_rd", mem_rd, 1);
        check("lat_addr", mem_address, 0);
        check("lat_busy", busy, 1);
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;
        check("lat_valid", pix_valid, 1);
        check("lat_top", pix_top, 12'h000);
        check("lat_bot", pix_bot, 12'hFFF);
        check("lat_sol", pix_sol, 1);
        wait_idle("f1", DEPTH + 20);
        @(negedge clk);
        check("f1_pops", pop_total, DEPTH);
        check("f1_span", last_pop - first_pop, DEPTH - 1);
        check("f1_done", done_total, 1);

        // Random 50% backpressure.
        pop_total = 0; done_total = 0; start = 1'b1;
        pix_ready = 1'($urandom_range(0, 1));
        @(negedge clk); start = 1'b0;
        n = 0;
        while (busy && n < 8 * DEPTH) begin
            pix_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        check("bp_idle", busy, 0);
        check("bp_pops", pop_total, DEPTH);
        check("bp_done", done_total, 1);

        // Stall on the last column of line 0, then looping playback.
        loop_en = 1'b1; pix_ready = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 0; n = 0;
        while (!found && n < 200) begin
            if (pix_valid && pix_eol && pix_row == '0) found = 1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        pix_ready = 1'b0;
        check("eol_found", found, 1);
        for (int i = 0; i < 20; i++) begin
            check("stall_eol", pix_eol, 1);
            check("stall_row", pix_row, 0);
            check("stall_top", pix_top, 12'h03F);
            @(negedge clk);
        end
        check("stall_rd", mem_rd, 0);
        check("stall_valid", pix_valid, 1);
        pix_ready = 1'b1;
        @(posedge clk); #1;
        check("resume_sol", pix_sol, 1);
        check("resume_row", pix_row, 1);
        check("resume_top", pix_top, 12'h040);

        loops = 0; dropped = 0; n = 0;
        while (loops < 3 && n < 4 * DEPTH + 100) begin
            @(posedge clk); #1;
            n++;
            if (!busy) dropped = 1;
            if (frame_done) begin
                loops++;
                check("loop_addr", mem_address, 0);
                check("loop_rd", mem_rd, 1);
            end
        end
        check("loop_count", loops, 3);
        check("loop_busy", dropped, 0);
        @(negedge clk) loop_en = 1'b0;
        wait_idle("loop_end", DEPTH + 40);

        // Reset mid-frame near index 1000, then a fresh start.
        @(negedge clk);
        pop_total = 0; pix_ready = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (pop_total < 1000 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("mid_reached", pop_total >= 1000, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("rst_b");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        check("restart_rd", mem_rd, 1);
        check("restart_addr", mem_address, 0);
        @(negedge clk) start = 1'b0;
        wait_idle("f5", DEPTH + 20);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
